// File: rtl/jk_ctrl_pkg.sv
// rtl/jk_ctrl_pkg.sv - shared JK op codes, FSM state encoding and JK next-state helper
//
// Contents:
//   OP_HOLD/OP_RST/OP_SET/OP_TGL  {J,K} command encodings
//   state_t                       ST_IDLE / ST_APPLY
//   jk_next()                     next flop value for a given {J,K}

package jk_ctrl_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_t;

    function automatic logic jk_next(input logic q, input logic [1:0] jk);
        logic v;
        case (jk)
            OP_RST:  v = 1'b0;
            OP_SET:  v = 1'b1;
            OP_TGL:  v = ~q;
            default: v = q;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with synchronous active-high reset
//
// Ports:
//   clk  in   clock
//   rst  in   synchronous reset, active-high (q <= 0)
//   i_j  in   J input
//   i_k  in   K input
//   o_q  out  flop state

module jk_cell
    import jk_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= jk_next(r_q, {i_j, i_k});
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin arbitration of single-flop commands onto a shared JK flop bank
//
// Ports:
//   clk          in   clock, all state on posedge
//   rst          in   synchronous reset, active-high
//   i_req_valid  in   [NUM_REQ]        per-requester command valid
//   i_req_op     in   [2*NUM_REQ]      per-requester {J,K}
//   i_req_idx    in   [IDX_W*NUM_REQ]  per-requester target flop index
//   o_req_ready  out  [NUM_REQ]        one-hot accept, combinational, IDLE only
//   o_q          out  [NUM_FF]         flop bank state
//   o_grant_id   out  [RID_W]          id of last accepted requester
//   o_busy       out  high while the FSM is in APPLY
//   o_err        out  sticky, an accepted command addressed idx >= NUM_FF

module jk_bank_arbiter
    import jk_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_FF  = 8,
    parameter int IDX_W   = $clog2(NUM_FF),
    parameter int RID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [2*NUM_REQ-1:0]     i_req_op,
    input  logic [IDX_W*NUM_REQ-1:0] i_req_idx,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic [NUM_FF-1:0]        o_q,
    output logic [RID_W-1:0]         o_grant_id,
    output logic                     o_busy,
    output logic                     o_err
);

    localparam logic [RID_W:0] REQ_CNT = (RID_W+1)'(NUM_REQ);
    localparam logic [IDX_W:0] FF_CNT  = (IDX_W+1)'(NUM_FF);

    state_t             r_state;
    logic [RID_W-1:0]   r_grant_id;
    // Requester that has highest priority next; kept apart from r_grant_id
    // so that after reset requester 0 wins while grant_id still reads 0.
    logic [RID_W-1:0]   r_rr_ptr;
    logic [1:0]         r_op;
    logic [IDX_W-1:0]   r_idx;
    logic               r_busy;
    logic               r_err;

    logic [NUM_REQ-1:0] w_rot;
    logic               w_found;
    logic [RID_W-1:0]   w_off;
    logic [RID_W:0]     w_sum;
    logic [RID_W:0]     w_sum_wrap;
    logic [RID_W-1:0]   w_winner;
    logic [RID_W-1:0]   w_next_ptr;
    logic               w_accept;
    logic [NUM_REQ-1:0] w_ready;
    logic [1:0]         w_sel_op;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_idx_ok;
    logic [NUM_FF-1:0]  w_j;
    logic [NUM_FF-1:0]  w_k;

    // Rotate valids so bit 0 is the requester at r_rr_ptr.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = int'(r_rr_ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            w_rot[i] = i_req_valid[k];
        end
    end

    // Lowest set bit of the rotated vector is the winner's offset.
    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_off   = RID_W'(i);
            end
        end
    end

    // Rotate the offset back into an absolute requester id.
    assign w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_sum_wrap = w_sum - REQ_CNT;
    assign w_winner   = (w_sum >= REQ_CNT) ? w_sum_wrap[RID_W-1:0] : w_sum[RID_W-1:0];
    assign w_next_ptr = (w_winner == RID_W'(NUM_REQ - 1)) ? '0 : w_winner + RID_W'(1);

    assign w_accept = (r_state == ST_IDLE) && !rst && w_found;

    always_comb begin
        w_ready   = '0;
        w_sel_op  = OP_HOLD;
        w_sel_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == RID_W'(i)) begin
                w_ready[i] = w_accept;
                w_sel_op   = i_req_op[2*i +: 2];
                w_sel_idx  = i_req_idx[IDX_W*i +: IDX_W];
            end
        end
    end

    // Indices past the bank (only possible when NUM_FF is not a power of 2)
    // address no flop and raise err instead.
    assign w_idx_ok = ({1'b0, r_idx} < FF_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_op       <= OP_HOLD;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op       <= w_sel_op;
                        r_idx      <= w_sel_idx;
                        r_grant_id <= w_winner;
                        r_rr_ptr   <= w_next_ptr;
                        r_busy     <= 1'b1;
                        r_state    <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (!w_idx_ok) begin
                        r_err <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Only the addressed flop sees the command; everything else holds.
    always_comb begin
        w_j = '0;
        w_k = '0;
        if (r_state == ST_APPLY) begin
            for (int i = 0; i < NUM_FF; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    w_j[i] = r_op[1];
                    w_k[i] = r_op[0];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_FF; g++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .i_j (w_j[g]),
            .i_k (w_k[g]),
            .o_q (o_q[g])
        );
    end

    assign o_req_ready = w_ready;
    assign o_grant_id  = r_grant_id;
    assign o_busy      = r_busy;
    assign o_err       = r_err;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - randomized and directed self-checking bench for jk_bank_arbiter

module tb_jk_bank_arbiter;

    localparam int NR  = 4;
    localparam int NF  = 8;
    localparam int NFB = 6;
    localparam int IW  = 3;
    localparam int RW  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NR-1:0]    a_valid;
    logic [2*NR-1:0]  a_op;
    logic [IW*NR-1:0] a_idx;
    logic [NR-1:0]    a_ready;
    logic [NF-1:0]    a_q;
    logic [RW-1:0]    a_grant;
    logic             a_busy;
    logic             a_err;

    logic             b_rst;
    logic [NR-1:0]    b_valid;
    logic [2*NR-1:0]  b_op;
    logic [IW*NR-1:0] b_idx;
    logic [NR-1:0]    b_ready;
    logic [NFB-1:0]   b_q;
    logic [RW-1:0]    b_grant;
    logic             b_busy;
    logic             b_err;

    jk_bank_arbiter #(.NUM_REQ(NR), .NUM_FF(NF)) u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (a_valid),
        .i_req_op    (a_op),
        .i_req_idx   (a_idx),
        .o_req_ready (a_ready),
        .o_q         (a_q),
        .o_grant_id  (a_grant),
        .o_busy      (a_busy),
        .o_err       (a_err)
    );

    jk_bank_arbiter #(.NUM_REQ(NR), .NUM_FF(NFB)) u_dut_b (
        .clk         (clk),
        .rst         (b_rst),
        .i_req_valid (b_valid),
        .i_req_op    (b_op),
        .i_req_idx   (b_idx),
        .o_req_ready (b_ready),
        .o_q         (b_q),
        .o_grant_id  (b_grant),
        .o_busy      (b_busy),
        .o_err       (b_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    // Reference model: a command list view of the bank.
    logic [NF-1:0] m_q;
    bit            m_busy;
    bit            m_err;
    int            m_grant;
    int            m_next;
    int            m_op;
    int            m_idx;
    int            m_last_win;

    function automatic int model_winner();
        if (m_busy || rst) return -1;
        for (int k = 0; k < NR; k++) begin
            int r;
            r = (m_next + k) % NR;
            if (a_valid[r]) return r;
        end
        return -1;
    endfunction

    task automatic model_edge(input int w);
        if (rst) begin
            m_q = '0; m_busy = 0; m_err = 0; m_grant = 0; m_next = 0;
        end else if (m_busy) begin
            if (m_idx < NF) begin
                case (m_op)
                    1: m_q[m_idx] = 1'b0;
                    2: m_q[m_idx] = 1'b1;
                    3: m_q[m_idx] = ~m_q[m_idx];
                    default: ;
                endcase
            end else begin
                m_err = 1;
            end
            m_busy = 0;
        end else if (w >= 0) begin
            m_grant = w;
            m_next  = (w + 1) % NR;
            m_op    = int'(a_op[2*w +: 2]);
            m_idx   = int'(a_idx[IW*w +: IW]);
            m_busy  = 1;
        end
    endtask

    // Inputs are set before calling; checks happen mid-cycle, then one edge.
    task automatic tick();
        int w;
        logic [NR-1:0] exp_rdy;
        #1;
        w = model_winner();
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("ready", 32'(a_ready), 32'(exp_rdy));
        check("busy",  32'(a_busy),  32'(m_busy));
        check("q",     32'(a_q),     32'(m_q));
        check("grant", 32'(a_grant), 32'(m_grant));
        check("err",   32'(a_err),   32'(m_err));
        m_last_win = w;
        model_edge(w);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick_b();
        @(posedge clk);
        @(negedge clk);
    endtask

    int rr_order [5] = '{0, 1, 2, 3, 0};
    int rr_q     [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};

    initial begin
        rst = 1'b1; a_valid = 4'hF; a_op = '0; a_idx = '0;
        b_rst = 1'b1; b_valid = '0; b_op = '0; b_idx = '0;
        m_q = '0; m_busy = 0; m_err = 0; m_grant = 0; m_next = 0;
        m_op = 0; m_idx = 0; m_last_win = -1;
        @(posedge clk);
        @(negedge clk);

        // reset state with valids asserted: ready must stay low
        tick();
        tick();
        check("rst_grant", 32'(a_grant), 0);

        // single set: req0 op=10 idx=3
        a_valid = '0;
        rst = 1'b0;
        a_valid = 4'b0001; a_op[1:0] = 2'b10; a_idx[2:0] = 3'd3;
        #1 check("set_rdy", 32'(a_ready), 32'h1);
        tick();
        a_valid = '0;
        check("set_busy", 32'(a_busy), 1);
        tick();
        check("set_q", 32'(a_q), 32'h08);

        // round robin toggles, from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_valid = 4'hF; a_op = 8'hFF; a_idx = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int n = 0; n < 5; n++) begin
            tick();
            check("rr_grant", 32'(a_grant), 32'(rr_order[n]));
            tick();
            check("rr_q", 32'(a_q), 32'(rr_q[n]));
        end

        // reset for two cycles during APPLY
        tick();
        check("pre_rst_busy", 32'(a_busy), 1);
        rst = 1'b1;
        #1 check("rst_rdy", 32'(a_ready), 0);
        tick();
        tick();
        check("mid_rst_q", 32'(a_q), 0);
        check("mid_rst_busy", 32'(a_busy), 0);
        check("mid_rst_err", 32'(a_err), 0);
        check("mid_rst_grant", 32'(a_grant), 0);
        rst = 1'b0;
        a_valid = '0;

        // hold/clear from req2
        a_valid = 4'b0100; a_op[5:4] = 2'b10;
        for (int i = 0; i < NF; i++) begin
            a_idx[8:6] = 3'(i);
            tick();
            tick();
        end
        check("fill_q", 32'(a_q), 32'hFF);
        a_op[5:4] = 2'b00; a_idx[8:6] = 3'd5;
        tick();
        tick();
        check("hold_q", 32'(a_q), 32'hFF);
        check("hold_grant", 32'(a_grant), 2);
        a_op[5:4] = 2'b01;
        tick();
        tick();
        check("clr_q", 32'(a_q), 32'hDF);
        check("clr_grant", 32'(a_grant), 2);
        a_valid = '0;
        tick();

        // random traffic; pending requests stay stable or are withdrawn
        for (int c = 0; c < 600; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (a_valid[r] && m_last_win != r) begin
                    if ($urandom_range(0, 7) == 0) a_valid[r] = 1'b0;
                end else begin
                    a_valid[r] = 1'($urandom_range(0, 1));
                    a_op[2*r +: 2] = 2'($urandom_range(0, 3));
                    a_idx[IW*r +: IW] = 3'($urandom_range(0, 7));
                end
            end
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0;
        a_valid = '0;

        // bad index on the 6-flop bank
        tick_b();
        b_rst = 1'b0;
        b_valid = 4'b0010; b_op[3:2] = 2'b10; b_idx[5:3] = 3'd7;
        #1 check("bad_rdy", 32'(b_ready), 32'h2);
        tick_b();
        b_valid = '0;
        check("bad_busy", 32'(b_busy), 1);
        check("bad_grant", 32'(b_grant), 1);
        tick_b();
        check("bad_q", 32'(b_q), 0);
        check("bad_err", 32'(b_err), 1);
        b_valid = 4'b0001; b_op[1:0] = 2'b10; b_idx[2:0] = 3'd2;
        tick_b();
        b_valid = '0;
        tick_b();
        check("bad_q2", 32'(b_q), 32'h04);
        check("bad_err_sticky", 32'(b_err), 1);
        tick_b();
        check("bad_err_hold", 32'(b_err), 1);
        b_rst = 1'b1;
        tick_b();
        check("bad_err_clr", 32'(b_err), 0);
        check("bad_q_clr", 32'(b_q), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
